// File: rtl/vec_norm_pkg.sv
// Shared helpers for the block-floating-point vector normaliser:
// default geometry, clog2, sig-bit count width and channel slice helpers.
package vec_norm_pkg;

    localparam int unsigned DEF_IN_W  = 20;
    localparam int unsigned DEF_OUT_W = 9;
    localparam int unsigned DEF_CH    = 3;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width needed to hold a significant-bit count in 0..in_w.
    function automatic int unsigned shw_of(input int unsigned in_w);
        return clog2(in_w + 1);
    endfunction

    // Low bit index of channel idx in a packed vector of w-bit channels.
    function automatic int unsigned ch_lo(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/vec_block_normalize_sig_bits.sv
// Significant-bit counter for one signed channel: smallest n such that the
// value fits an n-bit two's-complement field (0 and -1 give n=1).
// Found by locating the highest bit that differs from the sign bit.
module vec_sig_bits
    import vec_norm_pkg::*;
#(
    parameter int unsigned IN_W = DEF_IN_W,
    parameter int unsigned SHW  = shw_of(DEF_IN_W)
) (
    input  logic [IN_W-1:0] val,
    output logic [SHW-1:0]  n
);

    // Leading-sign-bit detect: last (highest) differing bit wins.
    always_comb begin
        n = SHW'(1);
        for (int unsigned k = 0; k < IN_W - 1; k++) begin
            if (val[k] != val[IN_W-1]) begin
                n = SHW'(k + 2);
            end
        end
    end

endmodule

// File: rtl/vec_block_normalize.sv
// Three-stage block-floating-point normaliser for CH signed channels.
// S1 counts significant bits per channel, S2 takes the maximum and derives
// a common right shift, S3 applies it and presents the result.
// Optional feature macro: VEC_NORM_ROUND_EN (round half up + saturate in S3).
module vec_block_normalize
    import vec_norm_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned OUT_W = DEF_OUT_W,
    parameter int unsigned CH    = DEF_CH,
    localparam int unsigned SHW  = shw_of(IN_W)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH*IN_W-1:0]    in_vec,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CH*OUT_W-1:0]   out_vec,
    output logic [SHW-1:0]        out_shift
);

    localparam logic [SHW-1:0] OUT_W_S = SHW'(OUT_W);

    logic                 en1, en2, en3;
    logic                 v1, v2, v3;
    logic [CH*IN_W-1:0]   vec1, vec2;
    logic [SHW-1:0]       n_comb [CH];
    logic [SHW-1:0]       n1     [CH];
    logic [SHW-1:0]       m_comb;
    logic [SHW-1:0]       shift_comb;
    logic [SHW-1:0]       shift2;
    logic signed [IN_W-1:0] chan2 [CH];
    logic [CH*OUT_W-1:0]  res_comb;

    // Per-channel significant-bit counters on the incoming vector.
    for (genvar i = 0; i < CH; i++) begin : g_sig
        vec_sig_bits #(
            .IN_W (IN_W),
            .SHW  (SHW)
        ) u_sig (
            .val (in_vec[ch_lo(i, IN_W) +: IN_W]),
            .n   (n_comb[i])
        );
    end

    // Backpressure chain from the output back to the input, no bubbles.
    always_comb begin
        en3      = !v3 || out_ready;
        en2      = !v2 || en3;
        en1      = !v1 || en2;
        in_ready = en1;
    end

    assign out_valid = v3;

    // S1: capture vector and per-channel bit counts (only on a real transfer).
    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            vec1 <= '0;
            for (int unsigned i = 0; i < CH; i++) begin
                n1[i] <= '0;
            end
        end else if (en1) begin
            v1 <= in_valid;
            if (in_valid) begin
                vec1 <= in_vec;
                n1   <= n_comb;
            end
        end
    end

    // Max reduction over channels and block exponent derivation.
    always_comb begin
        m_comb = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (n1[i] > m_comb) begin
                m_comb = n1[i];
            end
        end
        shift_comb = (m_comb > OUT_W_S) ? (m_comb - OUT_W_S) : '0;
    end

    // S2: register the common shift alongside the vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2     <= 1'b0;
            vec2   <= '0;
            shift2 <= '0;
        end else if (en2) begin
            v2 <= v1;
            if (v1) begin
                vec2   <= vec1;
                shift2 <= shift_comb;
            end
        end
    end

    // Unpack S2 channels as signed values for the shifter.
    always_comb begin
        for (int unsigned i = 0; i < CH; i++) begin
            chan2[i] = vec2[ch_lo(i, IN_W) +: IN_W];
        end
    end

`ifdef VEC_NORM_ROUND_EN
    logic signed [IN_W:0] bias;
    logic signed [IN_W:0] wide   [CH];
    logic signed [IN_W:0] rshift [CH];

    localparam logic signed [IN_W:0] SAT_MAX = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] SAT_MIN = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    // Round half up by adding 2^(shift-1) one bit wider, then shift and saturate.
    always_comb begin
        bias     = '0;
        res_comb = '0;
        if (shift2 != '0) begin
            bias[shift2 - 1'b1] = 1'b1;
        end
        for (int unsigned i = 0; i < CH; i++) begin
            wide[i]   = {chan2[i][IN_W-1], chan2[i]} + bias;
            rshift[i] = wide[i] >>> shift2;
            if (rshift[i] > SAT_MAX) begin
                res_comb[ch_lo(i, OUT_W) +: OUT_W] = {1'b0, {(OUT_W-1){1'b1}}};
            end else if (rshift[i] < SAT_MIN) begin
                res_comb[ch_lo(i, OUT_W) +: OUT_W] = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                res_comb[ch_lo(i, OUT_W) +: OUT_W] = rshift[i][OUT_W-1:0];
            end
        end
    end
`else
    // Truncating arithmetic shift; the chosen shift guarantees the result fits.
    always_comb begin
        res_comb = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            res_comb[ch_lo(i, OUT_W) +: OUT_W] = OUT_W'(chan2[i] >>> shift2);
        end
    end
`endif

    // S3: output register, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3        <= 1'b0;
            out_vec   <= '0;
            out_shift <= '0;
        end else if (en3) begin
            v3 <= v2;
            if (v2) begin
                out_vec   <= res_comb;
                out_shift <= shift2;
            end
        end
    end

endmodule
